srt_operand_normalizer: RTL and testbench
=========================================

Name: srt_operand_normalizer

Overview:
- Pre-stage that sits directly upstream of the radix-4 SRT divider.
- The divider's quotient-select table only indexes divisor top nibbles 1000..1111, so the divisor must arrive with its MSB set. The divider also reads the dividend combinationally while idle, so the dividend must be held stable.
- This block accepts raw 8-bit operands and normalizes them by serial left shift, one bit per cycle. It rejects divide-by-zero and dividend overflow, pulses the divider's start, then holds its operands stable until the divider reports completion.

Parameters:
- WIDTH, 8, operand width; must match the divider's N/D width.
- SHW, 3, shift-count width, equal to clog2(WIDTH).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  raw operands valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- n_in  in  WIDTH  raw dividend.
- d_in  in  WIDTH  raw divisor.
- n_norm  out  WIDTH  normalized dividend, drives divider N.
- d_norm  out  WIDTH  normalized divisor, drives divider D; MSB=1 whenever div_start fires.
- shamt  out  SHW  number of left shifts applied; valid from LAUNCH through HOLD.
- div_start  out  1  one-cycle start pulse to the divider.
- div_done  in  1  divider completion (divider done flag).
- busy  out  1  high in every state except IDLE.
- err_valid  out  1  one-cycle pulse reporting a rejected operand pair.
- err_div0  out  1  qualifies err_valid: divisor was zero.
- err_ovf  out  1  qualifies err_valid: the dividend MSB would be lost by normalization.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; n_norm=0, d_norm=0, shamt=0; div_start=0, err_valid=0, err_div0=0, err_ovf=0, busy=0; in_ready=1 once reset deasserts.
- States: IDLE, NORM, LAUNCH, HOLD, ERR.
- IDLE:
  - in_ready=1.
  - On in_valid: load n_norm<=n_in, d_norm<=d_in, shamt<=0, then go to NORM.
- NORM (one evaluation per cycle, priority order):
  - d_norm==0 -> ERR with err_div0.
  - Else d_norm[WIDTH-1]==1 -> LAUNCH.
  - Else n_norm[WIDTH-1]==1 -> ERR with err_ovf.
  - Else shift both n_norm and d_norm left by 1 (zero fill), shamt+=1, stay in NORM.
- LAUNCH: div_start=1 for exactly this cycle, then go to HOLD.
- HOLD:
  - n_norm, d_norm and shamt are frozen.
  - Stay until div_done==1, then go to IDLE.
  - div_done is sampled only in HOLD; it is ignored in all other states, including the LAUNCH cycle.
- ERR:
  - err_valid=1 for one cycle, with exactly one of err_div0/err_ovf high; then go to IDLE.
  - err_div0/err_ovf clear when leaving ERR.
  - div_start is never asserted for a rejected pair.
- Latency: with acceptance at edge t and k required shifts, div_start is high in the cycle after edge t+k+1. So D=0x80 gives start 2 cycles after acceptance, and D=0x01 gives start 9 cycles after acceptance.
- shamt never exceeds WIDTH-1: for a nonzero D, NORM exits after at most WIDTH-1 shifts.
- in_valid while busy is ignored (in_ready=0); no operands are lost or queued.
- Asserting reset in any state aborts immediately to the reset values. A divider left mid-operation must itself be reset by the system reset.

Decomposition:
- Shared package:
  - State encoding constants (IDLE/NORM/LAUNCH/HOLD/ERR, 3-bit).
  - WIDTH/SHW defaults, also used by the divider wrapper.
  - Error-code constants.
- No sub-module. The shifter is a single registered datapath inside the FSM; a leading-zero counter is not used because serial shift is the decided behaviour.

Test Plan:
- N=0x0C, D=0x20, in_valid one cycle -> 2 shifts; div_start pulses 4 cycles after acceptance with n_norm=0x30, d_norm=0x80, shamt=2; outputs held until div_done, then in_ready=1.
- N=0x35, D=0x9A -> no shift; div_start 2 cycles after acceptance; n_norm=0x35, d_norm=0x9A, shamt=0.
- N=0x12, D=0x00 -> err_valid and err_div0 high for one cycle, err_ovf=0, div_start never asserted, back to IDLE.
- N=0x40, D=0x10 -> one shift (n=0x80, d=0x20), then err_valid with err_ovf; no div_start.
- In HOLD, drive in_valid with new operands and hold div_done=0 for 10 cycles -> in_ready=0, n_norm/d_norm/shamt unchanged; pulse div_done -> IDLE next cycle.
- N=0x01, D=0x01, assert reset asynchronously during the 3rd NORM cycle -> all outputs return to reset values without waiting for a clock edge; a new transaction after reset completes normally (shamt=7, d_norm=0x80, n_norm=0x80).

Source files
------------

// File: rtl/srt_operand_normalizer_pkg.sv
// Shared constants for the SRT operand normalizer and the divider wrapper.
//   DEF_WIDTH / DEF_SHW : operand width and shift-count width
//   state_e             : normalizer FSM encoding (3-bit)
//   err_e               : rejection reason codes
package srt_operand_normalizer_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_SHW   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NORM   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_DIV0 = 2'd1,
    ERR_OVF  = 2'd2
  } err_e;

endpackage

// File: rtl/srt_operand_normalizer_if.sv
// Operand/divider bus of the SRT operand normalizer.
//   slave  : normalizer side (takes raw operands and div_done, drives the rest)
//   master : upstream source plus divider side
interface srt_operand_normalizer_if
  import srt_operand_normalizer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SHW   = DEF_SHW
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] n_in;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] n_norm;
  logic [WIDTH-1:0] d_norm;
  logic [SHW-1:0]   shamt;
  logic             div_start;
  logic             div_done;
  logic             busy;
  logic             err_valid;
  logic             err_div0;
  logic             err_ovf;

  modport slave (
    input  in_valid, n_in, d_in, div_done,
    output in_ready, n_norm, d_norm, shamt, div_start, busy,
           err_valid, err_div0, err_ovf
  );

  modport master (
    output in_valid, n_in, d_in, div_done,
    input  in_ready, n_norm, d_norm, shamt, div_start, busy,
           err_valid, err_div0, err_ovf
  );

endinterface

// File: rtl/srt_operand_normalizer.sv
// Serial left-shift normalizer in front of the radix-4 SRT divider.
// Shifts the divisor (and dividend) until the divisor MSB is set, rejects
// divide-by-zero and dividend overflow, pulses div_start and then holds the
// operands frozen until the divider reports completion.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : operand / divider interface (slave modport)
module srt_operand_normalizer
  import srt_operand_normalizer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SHW   = DEF_SHW
) (
  input  logic                     clk,
  input  logic                     reset,
  srt_operand_normalizer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [SHW-1:0]   sh_q, sh_d;
  err_e             err_d;

  logic in_ready_q, busy_q, start_q, err_valid_q, err_div0_q, err_ovf_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath next values
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    sh_d    = sh_q;
    err_d   = ERR_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          n_d     = bus.n_in;
          d_d     = bus.d_in;
          sh_d    = '0;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        // Divisor checks take priority: a set divisor MSB means the dividend
        // MSB is never shifted out on this pass.
        if (d_q == '0) begin
          state_d = ST_ERR;
          err_d   = ERR_DIV0;
        end else if (d_q[WIDTH-1]) begin
          state_d = ST_LAUNCH;
        end else if (n_q[WIDTH-1]) begin
          state_d = ST_ERR;
          err_d   = ERR_OVF;
        end else begin
          n_d  = {n_q[WIDTH-2:0], 1'b0};
          d_d  = {d_q[WIDTH-2:0], 1'b0};
          sh_d = sh_q + SHW'(1);
        end
      end
      ST_LAUNCH: state_d = ST_HOLD;
      ST_HOLD:   if (bus.div_done) state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Operand registers and registered status outputs (decoded from next state)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q         <= '0;
      d_q         <= '0;
      sh_q        <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      err_valid_q <= 1'b0;
      err_div0_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      n_q         <= n_d;
      d_q         <= d_d;
      sh_q        <= sh_d;
      in_ready_q  <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      start_q     <= (state_d == ST_LAUNCH);
      err_valid_q <= (state_d == ST_ERR);
      err_div0_q  <= (err_d == ERR_DIV0);
      err_ovf_q   <= (err_d == ERR_OVF);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.div_start = start_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_div0  = err_div0_q;
  assign bus.err_ovf   = err_ovf_q;
  assign bus.n_norm    = n_q;
  assign bus.d_norm    = d_q;
  assign bus.shamt     = sh_q;

endmodule

// File: tb/tb_srt_operand_normalizer.sv
// Self-checking bench for srt_operand_normalizer: directed cases followed by
// random operand pairs, all checked against an arithmetic reference model.
module tb_srt_operand_normalizer;

  logic clk = 1'b0;
  logic reset;
  int   vectors    = 0;
  int   miscompares = 0;

  srt_operand_normalizer_if bus ();

  srt_operand_normalizer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one operand pair and follow it to completion.
  task automatic run_txn(input logic [7:0] n, input logic [7:0] d,
                         input int hold_cycles, input bit done_in_launch);
    int k, j, cnt, nn, dd, exp_cycles;
    bit div0, ovf;
    logic [7:0] exp_n, exp_d;
    // Reference model: shifts needed to bring d's MSB up, and whether the
    // dividend overflows 8 bits before that happens.
    div0 = (d == 8'h00);
    k = 0;
    if (!div0) begin
      dd = int'(d);
      while (dd < 128) begin dd = dd * 2; k++; end
    end
    ovf = !div0 && ((int'(n) << k) > 255);
    j = 0;
    if (ovf) begin
      nn = int'(n);
      while (nn < 128) begin nn = nn * 2; j++; end
    end
    exp_n = 8'((int'(n) << k) & 255);
    exp_d = 8'((int'(d) << k) & 255);
    exp_cycles = div0 ? 1 : (ovf ? j + 1 : k + 1);

    check("idle_ready", 32'(bus.in_ready), 32'd1);
    bus.n_in = n; bus.d_in = d; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.n_in = 8'($urandom); bus.d_in = 8'($urandom);
    check("accept_busy", 32'(bus.busy), 32'd1);
    check("accept_ready", 32'(bus.in_ready), 32'd0);

    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt++;
      if (bus.err_valid === 1'b1 || bus.div_start === 1'b1) break;
    end
    check("latency", 32'(cnt), 32'(exp_cycles));
    check("start", 32'(bus.div_start), 32'(!(div0 || ovf)));
    check("err_valid", 32'(bus.err_valid), 32'(div0 || ovf));
    check("err_div0", 32'(bus.err_div0), 32'(div0));
    check("err_ovf", 32'(bus.err_ovf), 32'(ovf));

    if (div0 || ovf) begin
      tick();
      check("err_clear", 32'({bus.err_valid, bus.err_div0, bus.err_ovf, bus.div_start}), 32'd0);
      check("err_idle", 32'(bus.in_ready), 32'd1);
    end else begin
      check("n_norm", 32'(bus.n_norm), 32'(exp_n));
      check("d_norm", 32'(bus.d_norm), 32'(exp_d));
      check("d_msb", 32'(bus.d_norm[7]), 32'd1);
      check("shamt", 32'(bus.shamt), 32'(k));
      // div_done during LAUNCH must be ignored.
      bus.div_done = done_in_launch;
      tick();
      bus.div_done = 1'b0;
      check("start_pulse", 32'(bus.div_start), 32'd0);
      check("hold_busy", 32'(bus.busy), 32'd1);
      for (int i = 0; i < hold_cycles; i++) begin
        bus.in_valid = 1'b1;
        bus.n_in = 8'($urandom); bus.d_in = 8'($urandom);
        tick();
        check("hold_ready", 32'(bus.in_ready), 32'd0);
        check("hold_ops", 32'({bus.n_norm, bus.d_norm, 5'(bus.shamt)}),
              32'({exp_n, exp_d, 5'(k)}));
      end
      bus.in_valid = 1'b0;
      bus.div_done = 1'b1;
      tick();
      bus.div_done = 1'b0;
      check("done_ready", 32'(bus.in_ready), 32'd1);
      check("done_busy", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.n_in = '0; bus.d_in = '0; bus.div_done = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_ops", 32'({bus.n_norm, bus.d_norm, 5'(bus.shamt)}), 32'd0);
    check("rst_flags", 32'({bus.div_start, bus.err_valid, bus.err_div0, bus.err_ovf, bus.busy}), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);

    run_txn(8'h0C, 8'h20, 3, 1'b0);
    run_txn(8'h35, 8'h9A, 2, 1'b1);
    run_txn(8'h12, 8'h00, 0, 1'b0);
    run_txn(8'h40, 8'h10, 0, 1'b0);
    run_txn(8'h55, 8'hC3, 10, 1'b0);
    run_txn(8'h01, 8'h01, 1, 1'b0);

    // Async reset in the 3rd NORM cycle, away from any clock edge.
    bus.n_in = 8'h01; bus.d_in = 8'h01; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    check("arst_ops", 32'({bus.n_norm, bus.d_norm, 5'(bus.shamt)}), 32'd0);
    check("arst_flags", 32'({bus.div_start, bus.err_valid, bus.err_div0, bus.err_ovf, bus.busy}), 32'd0);
    tick();
    #2 reset = 1'b0;
    tick();
    check("arst_ready", 32'(bus.in_ready), 32'd1);
    run_txn(8'h01, 8'h01, 2, 1'b0);

    for (int t = 0; t < 60; t++) begin
      logic [7:0] rn, rd;
      rn = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
      rd = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) rd = 8'h00;
      run_txn(rn, rd, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
